if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  - Decoupling queue between instr_fetch_v2 (pc[10:0], instr_o[31:0]) and the decode stage.
//  - Buffers fetched {pc, instr} pairs so decode back-pressure stalls fetch without losing instructions.
//  - Discards all buffered instructions on a branch/jump redirect (flush).
//  - Provides a registered predecode class for the head entry so decode sees early branch/jump flags.
// PARAMETERS
//  DEPTH   2             queue entries; power of 2, >= 2
//  PC_W    11            PC width, matches instr_fetch_v2 pc
//  XLEN    32            instruction width
//  NOP     32'h00000013  instruction word driven when queue is empty (addi x0,x0,0)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  if_valid_i   in   1      fetch presents a valid {pc, instr} this cycle
//  if_pc_i      in   PC_W   PC of the fetched instruction
//  if_instr_i   in   XLEN   fetched instruction word
//  if_ready_o   out  1      queue accepts a push this cycle; fetch holds pc while low
//  flush_i      in   1      redirect: drop all entries and any same-cycle push
//  id_valid_o   out  1      head entry valid
//  id_ready_i   in   1      decode consumes head this cycle
//  id_pc_o      out  PC_W   head PC
//  id_instr_o   out  XLEN   head instruction word
//  id_is_br_o   out  1      head opcode is 1100011 (BRANCH)
//  id_is_jmp_o  out  1      head opcode is 1101111 (JAL) or 1100111 (JALR)
//  count_o      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset:
//    - wr_ptr = rd_ptr = count_o = 0.
//    - id_valid_o = 0, id_pc_o = 0, id_instr_o = NOP, id_is_br_o = id_is_jmp_o = 0.
//    - if_ready_o = 1 in the first cycle after rst deasserts.
//    - Reset asserted mid-operation discards all contents in that cycle.
//  - Push: push = if_valid_i & if_ready_o & ~flush_i. Writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
//  - Pop: pop = id_valid_o & id_ready_i & ~flush_i. Advances rd_ptr, which wraps modulo DEPTH.
//  - if_ready_o = (count_o != DEPTH).
//    - It depends on registered count only; there is no combinational path from id_ready_i.
//    - When full, a same-cycle pop does not enable a push. The push is accepted the following cycle.
//  - Count update:
//    - push only: +1
//    - pop only: -1
//    - push and pop together (count between 1 and DEPTH-1): unchanged
//    - neither: unchanged
//  - Empty (count_o == 0):
//    - id_valid_o = 0, id_instr_o = NOP, id_pc_o = 0, predecode flags = 0.
//    - id_ready_i is ignored.
//  - Latency:
//    - A push in cycle N is visible on id_* in cycle N+1. There is no bypass from if_* to id_*.
//    - Head outputs come from mem[rd_ptr], with predecode registered alongside the data at push time.
//  - Flush (highest priority after rst):
//    - Next cycle: count_o = 0, pointers = 0, id_valid_o = 0.
//    - The same-cycle push and same-cycle pop are both dropped.
//    - The next cycle accepts a push from the redirected PC.
//  - Ordering: strict FIFO; PC order out equals PC order in.
//  - Data that is in the queue is held stable while id_ready_i = 0.
//  - X/metastability: no async inputs; all state updates on posedge clk only.
// STRUCTURE
//  - rv32i_pkg (shared):
//    - OPC_BRANCH, OPC_JAL, OPC_JALR localparams.
//    - NOP_INSTR constant.
//    - typedef struct packed { logic [PC_W-1:0] pc; logic [XLEN-1:0] instr; logic is_br, is_jmp; } if_id_entry_t.
//  - Sub-module rv32i_predecode: combinational; takes instr[6:0] and outputs {is_br, is_jmp}.
//    - Instantiated on the push path.
//  - Storage: if_id_entry_t array [DEPTH], plus pointer/count registers. No other sub-modules.
// TESTING
//  - Reset then fill:
//    - Drive rst=1 for 2 cycles, then push pc=0,4 with instr 00000013 and 00500093, id_ready_i=0.
//    - Expect count_o=2, if_ready_o=0, id_pc_o=0.
//  - Drain order:
//    - From full, hold id_ready_i=1 for 2 cycles.
//    - Expect pc 0 then 4, id_valid_o=0 in cycle 3, id_instr_o=00000013.
//  - Full with simultaneous pop:
//    - Full with if_valid_i=1 and id_ready_i=1.
//    - Expect count_o=1 the next cycle and the push accepted the cycle after.
//    - No entry lost; pc sequence is contiguous.
//  - Flush with push:
//    - count_o=1, assert flush_i together with if_valid_i (pc=8).
//    - Expect count_o=0 the next cycle and pc=8 never appears on id_pc_o.
//  - Predecode:
//    - Push FE000EE3 (BEQ), 0000006F (JAL), 00008067 (JALR).
//    - Expect id_is_br_o = 1,0,0 and id_is_jmp_o = 0,1,1 in that order.
//  - Wrap / reset mid-run:
//    - Stream 10 pushes with pops so pointers wrap; expect in-order output.
//    - Assert rst mid-stream; expect count_o=0 and id_valid_o=0 the next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch/decode boundary: opcodes, the NOP word
// and the packed entry carried through the IF/ID queue.
package rv32i_pkg;

  localparam int PC_W = 11;
  localparam int XLEN = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            is_br;
    logic            is_jmp;
  } if_id_entry_t;

endpackage

// File: rtl/rv32i_predecode.sv
// Combinational opcode classifier feeding the queue write port, so the
// branch/jump flags are stored alongside each entry rather than decoded at the head.
module rv32i_predecode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       is_br_o,
  output logic       is_jmp_o
);

  assign is_br_o  = (opcode_i == OPC_BRANCH);
  assign is_jmp_o = (opcode_i == OPC_JAL) || (opcode_i == OPC_JALR);

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: push visible on id_* one cycle later, no bypass.
// if_ready_o depends only on registered occupancy; flush empties the queue next cycle.
module if_id_queue
  import rv32i_pkg::*;
#(
  parameter int              DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  input  logic [PC_W-1:0]          if_pc_i,
  input  logic [XLEN-1:0]          if_instr_i,
  output logic                     if_ready_o,
  input  logic                     flush_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [PC_W-1:0]          id_pc_o,
  output logic [XLEN-1:0]          id_instr_o,
  output logic                     id_is_br_o,
  output logic                     id_is_jmp_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_id_entry_t     mem_q [DEPTH];
  if_id_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         push;
  logic         pop;
  logic         empty;
  logic         pd_is_br;
  logic         pd_is_jmp;
  if_id_entry_t push_entry;
  if_id_entry_t head;

  rv32i_predecode u_predecode (
    .opcode_i (if_instr_i[6:0]),
    .is_br_o  (pd_is_br),
    .is_jmp_o (pd_is_jmp)
  );

  // A full queue refuses pushes even if decode pops in the same cycle, keeping
  // id_ready_i off the fetch handshake path.
  assign if_ready_o = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;

  always_comb begin
    push_entry.pc     = if_pc_i;
    push_entry.instr  = if_instr_i;
    push_entry.is_br  = pd_is_br;
    push_entry.is_jmp = pd_is_jmp;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: every head output is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr_q];

  assign id_valid_o  = ~empty;
  assign id_pc_o     = empty ? '0  : head.pc;
  assign id_instr_o  = empty ? NOP : head.instr;
  assign id_is_br_o  = ~empty & head.is_br;
  assign id_is_jmp_o = ~empty & head.is_jmp;
  assign count_o     = count_q;

endmodule
